// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if
//  Byte handshake between the host-side byte source (master) and the UART
//  transmit controller (slave). A byte moves on a rising clk where
//  tx_valid && tx_ready.
//  Signals:
//   tx_data   master -> slave  byte to send (DATA_BITS wide)
//   tx_valid  master -> slave  tx_data holds a byte to send
//   tx_ready  slave -> master  controller idle, can accept a byte
interface uart_tx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//  Sequences one UART transmit frame: start bit, DATA_BITS data bits LSB first,
//  optional parity bit, then STOP_BITS stop bits. Each bit lasts OVERSAMPLE
//  pulses of baud_tick, the oversampled tick from the baud generator.
//  Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   baud_tick  1-clk pulse at OVERSAMPLE x baud rate
//   bus        byte handshake (slave side: tx_data, tx_valid in; tx_ready out)
//   tx         serial line, idle high, registered
//   tx_busy    frame in progress (inverse of tx_ready)
//   tx_done    1-clk pulse after the final stop bit ends
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          baud_tick,
  uart_tx_ctrl_if.slave bus,
  output logic          tx,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be in 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_oversample
    $error("uart_tx_ctrl: OVERSAMPLE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bit, parity_next;
  logic                 tx_next;
  logic                 done_next;
  logic                 bit_end;

  // A bit period closes on the tick that completes OVERSAMPLE counted ticks.
  assign bit_end = baud_tick && (tick_cnt == TICK_LAST);

  assign bus.tx_ready = (state == IDLE);
  assign tx_busy      = (state != IDLE);

  // State register; tx and tx_done are registered copies of the next-state
  // decode so the line changes exactly one clk after each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      tick_cnt   <= tick_cnt_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      tx_done    <= done_next;
    end
  end

  // Next-state and next-line-value decode.
  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_next    = shift_reg;
    parity_next   = parity_bit;
    tx_next       = 1'b1;
    done_next     = 1'b0;

    // Ticks only count once a frame is running, so the tick that coincides
    // with acceptance is dropped and the start bit may be up to one tick
    // period shorter in wall time.
    if (state != IDLE && baud_tick) begin
      tick_cnt_next = bit_end ? '0 : tick_cnt + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        if (bus.tx_valid) begin
          shift_next    = bus.tx_data;
          parity_next   = (^bus.tx_data) ^ (PARITY_ODD != 0);
          tick_cnt_next = '0;
          bit_cnt_next  = '0;
          state_next    = START;
          tx_next       = 1'b0;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_next = '0;
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
            tx_next      = shift_reg[1];
          end
        end
      end
      PARITY: begin
        tx_next = parity_bit;
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        tx_next = 1'b1;
        // bit_cnt counts stop bits here so two stop bits need no extra state.
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//  Self-checking bench for uart_tx_ctrl. Four instances share clk, rst_n and
//  baud_tick: 8N1, 8E1, 8O1 and 7N2, all with OVERSAMPLE=16. A frame-level
//  reference model predicts tx/tx_ready/tx_busy/tx_done every cycle, a table
//  of hand-derived frames is sent and decoded from the line, and hand-written
//  sequences cover back-to-back sends and reset in the middle of a frame.
module tb_uart_tx_ctrl;

  localparam int OS   = 16;
  localparam int NDUT = 4;
  localparam int NVEC = 8;

  localparam int CFG_DB  [NDUT] = '{8, 8, 8, 7};
  localparam int CFG_PEN [NDUT] = '{0, 1, 1, 0};
  localparam int CFG_ODD [NDUT] = '{0, 0, 1, 0};
  localparam int CFG_SB  [NDUT] = '{1, 1, 1, 2};

  typedef struct {
    int         dut;
    logic [8:0] data;
    string      bits;
    int         ticks;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            baud_tick = 1'b0;
  logic [8:0]      dat [NDUT];
  logic [NDUT-1:0] vld;
  wire  [NDUT-1:0] tx_o;
  wire  [NDUT-1:0] busy_o;
  wire  [NDUT-1:0] done_o;
  wire  [NDUT-1:0] rdy_o;

  int errors = 0;
  int checks = 0;
  int tick_mode = 0;
  int tick_phase = 0;

  logic        m_act   [NDUT];
  int          m_n     [NDUT];
  logic        m_done  [NDUT];
  logic [15:0] m_frame [NDUT];

  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
  uart_tx_ctrl_if #(.DATA_BITS(8)) if2 ();
  uart_tx_ctrl_if #(.DATA_BITS(7)) if3 ();

  assign if0.tx_data  = dat[0][7:0];
  assign if1.tx_data  = dat[1][7:0];
  assign if2.tx_data  = dat[2][7:0];
  assign if3.tx_data  = dat[3][6:0];
  assign if0.tx_valid = vld[0];
  assign if1.tx_valid = vld[1];
  assign if2.tx_valid = vld[2];
  assign if3.tx_valid = vld[3];
  assign rdy_o[0]     = if0.tx_ready;
  assign rdy_o[1]     = if1.tx_ready;
  assign rdy_o[2]     = if2.tx_ready;
  assign rdy_o[3]     = if3.tx_ready;

  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if0),
    .tx(tx_o[0]), .tx_busy(busy_o[0]), .tx_done(done_o[0]));
  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if1),
    .tx(tx_o[1]), .tx_busy(busy_o[1]), .tx_done(done_o[1]));
  uart_tx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if2),
    .tx(tx_o[2]), .tx_busy(busy_o[2]), .tx_done(done_o[2]));
  uart_tx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .bus(if3),
    .tx(tx_o[3]), .tx_busy(busy_o[3]), .tx_done(done_o[3]));

  // Frame length in bit periods for instance d.
  function automatic int frameLen(input int d);
    return 1 + CFG_DB[d] + CFG_PEN[d] + CFG_SB[d];
  endfunction

  // Line levels of a whole frame, bit i of the result is bit period i.
  // Positions past the parity bit stay 1, which covers the stop bits.
  function automatic logic [15:0] frameOf(input int d, input logic [8:0] data);
    logic [15:0] f = '1;
    int pos = 1;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < CFG_DB[d]; i++) begin
      f[pos] = data[i];
      ones += int'(data[i]);
      pos++;
    end
    if (CFG_PEN[d] != 0) begin
      f[pos] = ((ones % 2) == 1) ^ (CFG_ODD[d] != 0);
    end
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkFrame(input string name, input string actual, input string expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got bits %s expected bits %s", name, actual, expected);
    end
  endtask

  // Offers a byte at the next negedge where the instance is ready; it is
  // taken on the following posedge. Returns 1 ns after that posedge.
  task automatic applyStimulus(input int d, input logic [8:0] data, input logic hold);
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (rdy_o[d]) begin
        dat[d] = data;
        vld[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) vld[d] = 1'b0;
        ok = 1'b1;
      end
    end
    checkOutput($sformatf("accept on dut%0d", d), 32'(ok), 32'd1);
  endtask

  // Decodes a frame from the line starting just after acceptance: samples
  // the middle of each bit period by counting ticks, stops at tx_done.
  task automatic captureFrame(input int d, output string bits, output int ticks, output logic first_tx);
    int n = 0;
    int last = -1;
    bits = "";
    ticks = -1;
    first_tx = 1'bx;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 0) first_tx = tx_o[d];
      if (done_o[d]) begin
        ticks = n;
        break;
      end
      if ((n % OS) == (OS / 2) && n != last) begin
        bits = {bits, (tx_o[d] ? "1" : "0")};
        last = n;
      end
      if (baud_tick) n++;
    end
  endtask

  // baud_tick: every 4th clk, or random phase for the randomized section.
  initial forever begin
    @(posedge clk);
    #1;
    if (tick_mode == 0) begin
      tick_phase = (tick_phase + 1) % 4;
      baud_tick  = (tick_phase == 0);
    end else begin
      baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Reference model: a frame is a list of line levels; once accepted, the
  // level shown is the entry for (ticks counted / OS) until all
  // frameLen*OS ticks have passed, then tx_done for one clk.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        m_act[d]   <= 1'b0;
        m_n[d]     <= 0;
        m_done[d]  <= 1'b0;
        m_frame[d] <= '1;
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        m_done[d] <= 1'b0;
        if (!m_act[d]) begin
          if (vld[d]) begin
            m_act[d]   <= 1'b1;
            m_n[d]     <= 0;
            m_frame[d] <= frameOf(d, dat[d]);
          end
        end else if (baud_tick) begin
          if (m_n[d] + 1 == frameLen(d) * OS) begin
            m_act[d]  <= 1'b0;
            m_done[d] <= 1'b1;
          end
          m_n[d] <= m_n[d] + 1;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("model tx dut%0d", d), 32'(tx_o[d]),
                  32'(m_act[d] ? m_frame[d][m_n[d] / OS] : 1'b1));
      checkOutput($sformatf("model tx_ready dut%0d", d), 32'(rdy_o[d]), 32'(!m_act[d]));
      checkOutput($sformatf("model tx_busy dut%0d", d), 32'(busy_o[d]), 32'(m_act[d]));
      checkOutput($sformatf("model tx_done dut%0d", d), 32'(done_o[d]), 32'(m_done[d]));
    end
  end

  initial begin
    string got;
    int    ticks;
    logic  first;
    int    n;
    bit    idle;

    tbl[0] = '{0, 9'h0A5, "0101001011",  160};
    tbl[1] = '{1, 9'h007, "01110000011", 176};
    tbl[2] = '{2, 9'h007, "01110000001", 176};
    tbl[3] = '{3, 9'h041, "0100000111",  160};
    tbl[4] = '{0, 9'h000, "0000000001",  160};
    tbl[5] = '{1, 9'h0FF, "01111111101", 176};
    tbl[6] = '{3, 9'h07F, "0111111111",  160};
    tbl[7] = '{2, 9'h080, "00000000101", 176};

    vld = '0;
    for (int d = 0; d < NDUT; d++) dat[d] = '0;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(tx_o[0]), 32'd1);
    checkOutput("reset tx_ready", 32'(rdy_o[0]), 32'd1);
    checkOutput("reset tx_busy", 32'(busy_o[0]), 32'd0);
    checkOutput("reset tx_done", 32'(done_o[0]), 32'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] frame table");
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(tbl[v].dut, tbl[v].data, 1'b0);
      captureFrame(tbl[v].dut, got, ticks, first);
      checkFrame($sformatf("frame v%0d", v), got, tbl[v].bits);
      checkOutput($sformatf("frame ticks v%0d", v), 32'(ticks), 32'(tbl[v].ticks));
      checkOutput($sformatf("start bit v%0d", v), 32'(first), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("tx_done one clk v%0d", v), 32'(done_o[tbl[v].dut]), 32'd0);
    end

    $display("[TB] back-to-back with tx_valid held");
    applyStimulus(0, 9'h055, 1'b1);
    dat[0] = 9'h0AA;
    captureFrame(0, got, ticks, first);
    checkFrame("b2b first byte", got, "0101010101");
    checkOutput("b2b first ticks", 32'(ticks), 32'd160);
    @(posedge clk);
    #1;
    dat[0] = 9'h0FF;
    vld[0] = 1'b0;
    captureFrame(0, got, ticks, first);
    checkOutput("b2b start one clk after done", 32'(first), 32'd0);
    checkFrame("b2b second byte", got, "0010101011");
    checkOutput("b2b second ticks", 32'(ticks), 32'd160);
    @(negedge clk);

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 9'h0F0, 1'b0);
    n = 0;
    for (int c = 0; c < 2000 && n < 4 * OS + OS / 2; c++) begin
      @(negedge clk);
      if (baud_tick) n++;
    end
    @(negedge clk);
    checkOutput("aborted frame data bit 3", 32'(tx_o[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-frame reset tx", 32'(tx_o[0]), 32'd1);
    checkOutput("mid-frame reset tx_ready", 32'(rdy_o[0]), 32'd1);
    checkOutput("mid-frame reset tx_busy", 32'(busy_o[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, 9'h03C, 1'b0);
    captureFrame(0, got, ticks, first);
    checkFrame("frame after reset", got, "0001111001");
    checkOutput("frame after reset ticks", 32'(ticks), 32'd160);

    $display("[TB] randomized traffic and tick phase");
    tick_mode = 1;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        vld[d] = ($urandom_range(0, 3) == 0);
        dat[d] = 9'($urandom);
      end
      if (c == 4000) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("random reset tx", 32'(tx_o), 32'hF);
        checkOutput("random reset tx_busy", 32'(busy_o), 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    vld = '0;
    tick_mode = 0;

    idle = 1'b0;
    for (int c = 0; c < 3000 && !idle; c++) begin
      @(negedge clk);
      idle = (rdy_o == '1);
    end
    checkOutput("drain to idle", 32'(idle), 32'd1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
